// File: rtl/shift_mult_unit_if.sv
// shift_mult_unit_if: start/busy/done request bus for the shift/multiply unit.
// The master drives the operands; the slave returns result, done and busy.
interface shift_mult_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, op, data1, data2,
    input  result, done, busy
  );

  modport slave (
    input  start, op, data1, data2,
    output result, done, busy
  );
endinterface

// File: rtl/shift_mult_unit.sv
// shift_mult_unit: single-cycle shifts/rotates and an 8-cycle shift-add
// multiply truncated to WIDTH bits, behind a start/busy/done handshake.
module shift_mult_unit #(
  parameter int WIDTH = 8
) (
  input logic              CLK,
  input logic              RESET,
  shift_mult_unit_if.slave bus
);
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [1:0] OP_LSH = 2'd0;
  localparam logic [1:0] OP_RSH = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_t state, state_nx;

  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [WIDTH-1:0]   result_q, shres, pp, sum;
  logic [2*WIDTH-1:0] rot2;
  logic [3:0]         amt;
  logic [1:0]         mode;
  logic [2:0]         cnt;
  logic               done_q, accept, last;

  assign accept = bus.start && (state == IDLE);
  assign last   = (state == MUL) && (cnt == 3'd7);

  // Shifts by 8..15 fall out of << / >>> as zero or sign fill.
  always_comb begin
    amt   = bus.data2[3:0];
    mode  = bus.data2[7:6];
    rot2  = {bus.data1, bus.data1} >> amt[2:0];
    shres = '0;
    unique case (1'b1)
      bus.op == OP_LSH:
        shres = bus.data1 << amt;
      bus.op == OP_RSH && mode == 2'b01:
        shres = $signed(bus.data1) >>> amt;
      bus.op == OP_RSH && mode == 2'b10:
        shres = rot2[WIDTH-1:0];
      bus.op == OP_RSH && mode[0] == mode[1]:
        shres = bus.data1 >> amt;
      default:
        shres = '0;
    endcase
  end

  assign pp  = mplier[0] ? mcand : '0;
  assign sum = acc + pp;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && bus.op == OP_MUL) state_nx = MUL;
      MUL:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == MUL);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (bus.op == OP_MUL) begin
          mcand  <= bus.data1;
          mplier <= bus.data2;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          result_q <= shres;
          done_q   <= 1'b1;
        end
      end else if (state == MUL) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 3'd1;
        if (last) begin
          result_q <= sum;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_shift_mult_unit.sv
// tb_shift_mult_unit: directed and random checks of shift_mult_unit
// against an arithmetic reference model.
module tb_shift_mult_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_mult_unit_if #(.WIDTH(8)) bus ();

  shift_mult_unit #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    int av, bv, amt, mode, sv, rt, r;
    av   = int'(a);
    bv   = int'(b);
    amt  = bv % 16;
    mode = bv / 64;
    sv   = (av >= 128) ? av - 256 : av;
    r    = 0;
    case (op)
      2'd0: r = (amt >= 8) ? 0 : av * (2 ** amt);
      2'd1: begin
        case (mode)
          1: r = (amt >= 8) ? ((av >= 128) ? 255 : 0) : (sv >>> amt);
          2: begin
            rt = amt % 8;
            r  = (av / (2 ** rt)) + av * (2 ** (8 - rt));
          end
          default: r = (amt >= 8) ? 0 : av / (2 ** amt);
        endcase
      end
      2'd2: r = av * bv;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic run(input logic [1:0] op,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input bit inject);
    logic [7:0] exp;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    @(posedge clk);
    #1;
    if (op != 2'd2) begin
      check("sh_done", {7'd0, bus.done}, 8'd1);
      check("sh_res", bus.result, exp);
      check("sh_busy", {7'd0, bus.busy}, 8'd0);
    end else begin
      check("mul_busy0", {7'd0, bus.busy}, 8'd1);
      check("mul_done0", {7'd0, bus.done}, 8'd0);
      for (int i = 1; i <= 7; i++) begin
        @(negedge clk);
        bus.start = inject && (i == 3);
        bus.op    = 2'($urandom_range(0, 3));
        bus.data1 = 8'($urandom);
        bus.data2 = 8'($urandom);
        @(posedge clk);
        #1;
        check("mul_busy", {7'd0, bus.busy}, 8'd1);
        check("mul_nodone", {7'd0, bus.done}, 8'd0);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.data1 = 8'($urandom);
    bus.data2 = 8'($urandom);
    if (op == 2'd2) begin
      @(posedge clk);
      #1;
      check("mul_done", {7'd0, bus.done}, 8'd1);
      check("mul_busy_end", {7'd0, bus.busy}, 8'd0);
      check("mul_res", bus.result, exp);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("done_pulse", {7'd0, bus.done}, 8'd0);
    check("res_hold", bus.result, exp);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.data1 = 8'h00;
    bus.data2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", bus.result, 8'h00);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'd0, 8'h0F, 8'h03, 1'b0);
    run(2'd1, 8'hF0, 8'h04, 1'b0);
    run(2'd1, 8'h80, 8'h42, 1'b0);
    run(2'd1, 8'h01, 8'h83, 1'b0);
    run(2'd0, 8'hFF, 8'h09, 1'b0);
    run(2'd1, 8'h80, 8'h4A, 1'b0);
    run(2'd1, 8'h01, 8'h89, 1'b0);
    run(2'd2, 8'h0C, 8'h0A, 1'b0);
    run(2'd2, 8'h10, 8'h10, 1'b0);
    run(2'd2, 8'hFF, 8'hFF, 1'b0);
    run(2'd3, 8'hA5, 8'h5A, 1'b0);
    run(2'd2, 8'h0D, 8'h0B, 1'b1);

    // abort a multiply with reset in its fourth busy cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.data1 = 8'h37;
    bus.data2 = 8'h29;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res", bus.result, 8'h00);
    check("abort_busy", {7'd0, bus.busy}, 8'd0);
    check("abort_done", {7'd0, bus.done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", {7'd0, bus.done}, 8'd0);
      check("abort_idle", {7'd0, bus.busy}, 8'd0);
    end
    run(2'd0, 8'h01, 8'h07, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
